// File: rtl/st_packet_arbiter.sv
// Two-input packet-level round-robin arbiter for the 32-bit Avalon-ST frame
// path feeding the UDP packet generator. Whole packets only; a packet that
// runs to MAX_WORDS beats is cut with a forced endofpacket and its remainder
// is drained from the source.
module st_packet_arbiter #(
  parameter int unsigned MAX_WORDS = 163,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_clk,
  input  logic             int_rst,
  input  logic [1:0]       src_enable,
  input  logic [31:0]      in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic             in0_sop,
  input  logic             in0_eop,
  input  logic [1:0]       in0_empty,
  input  logic [31:0]      in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic             in1_sop,
  input  logic             in1_eop,
  input  logic [1:0]       in1_empty,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic [1:0]       out_empty,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [7:0]       trunc_cnt
);

  localparam int unsigned     WC_W    = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  logic            last;
  logic [WC_W-1:0] wc;

  logic [1:0] req;
  logic       pick;
  logic       sel;
  logic       g_valid;
  logic       g_eop;
  logic       at_limit;
  logic       beat_ok;
  logic       drain_ok;

  assign req      = {in1_valid & src_enable[1], in0_valid & src_enable[0]};
  assign sel      = grant[1];
  assign g_valid  = sel ? in1_valid : in0_valid;
  assign g_eop    = sel ? in1_eop : in0_eop;
  assign at_limit = (wc == WC_LAST);
  assign beat_ok  = (state == PASS) & g_valid & out_ready;
  assign drain_ok = (state == DROP) & g_valid;

  // Round-robin pick: prefer the input that did not win last time.
  always_comb begin
    pick = 1'b0;
    if (last) begin
      pick = req[0] ? 1'b0 : 1'b1;
    end else begin
      pick = req[1] ? 1'b1 : 1'b0;
    end
  end

  // Zero-latency forwarding of the granted input; drain its leftovers in DROP.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_empty = '0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state)
      PASS: begin
        out_data  = sel ? in1_data : in0_data;
        out_valid = g_valid;
        out_sop   = sel ? in1_sop : in0_sop;
        out_eop   = g_eop | at_limit;
        out_empty = sel ? in1_empty : in0_empty;
        if (sel) begin
          in1_ready = out_ready;
        end else begin
          in0_ready = out_ready;
        end
      end
      DROP: begin
        if (sel) begin
          in1_ready = 1'b1;
        end else begin
          in0_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Packet FSM: arbitration, beat counting, completion and truncation counters.
  always_ff @(posedge clk_clk or posedge int_rst) begin
    if (int_rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      last      <= 1'b1;
      wc        <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      trunc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant <= pick ? 2'b10 : 2'b01;
            last  <= pick;
            wc    <= '0;
            state <= PASS;
          end
        end
        PASS: begin
          if (beat_ok) begin
            wc <= wc + WC_W'(1);
            if (g_eop) begin
              if (sel) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
              end else begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
              end
              grant <= 2'b00;
              state <= IDLE;
            end else if (at_limit) begin
              if (trunc_cnt != 8'hFF) begin
                trunc_cnt <= trunc_cnt + 8'd1;
              end
              state <= DROP;
            end
          end
        end
        DROP: begin
          if (drain_ok && g_eop) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_st_packet_arbiter.sv
// Directed bench for st_packet_arbiter: queued source beats, an expected
// output queue built from hand-derived packet order, and counter checks.
module tb_st_packet_arbiter;

  logic        clk_clk = 1'b0;
  logic        int_rst;
  logic [1:0]  src_enable;
  logic [31:0] in0_data, in1_data, out_data;
  logic        in0_valid, in0_ready, in0_sop, in0_eop;
  logic        in1_valid, in1_ready, in1_sop, in1_eop;
  logic [1:0]  in0_empty, in1_empty, out_empty;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [1:0]  grant;
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  trunc_cnt;

  st_packet_arbiter #(.MAX_WORDS(163), .CNT_W(16)) dut (
    .clk_clk(clk_clk), .int_rst(int_rst), .src_enable(src_enable),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_sop(in0_sop), .in0_eop(in0_eop), .in0_empty(in0_empty),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_sop(in1_sop), .in1_eop(in1_eop), .in1_empty(in1_empty),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
    .trunc_cnt(trunc_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic        src;
  } exp_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  xq[$];

  int ncmp = 0;
  int nerr = 0;
  int rdy_mode = 0;
  int stop_beats = 0;
  int outbeats, dropped, first_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one source packet; optionally queue what the output should show.
  task automatic add_pkt(input int src, input int n, input int eop_at,
                         input logic [31:0] base, input bit expect_out);
    beat_t b;
    exp_t  x;
    for (int i = 0; i < n; i++) begin
      b.d = base + 32'(i);
      b.s = (i == 0);
      b.e = (i == eop_at);
      if (src == 1) q1.push_back(b); else q0.push_back(b);
      if (expect_out && i < 163 && i <= eop_at) begin
        x.d   = b.d;
        x.s   = b.s;
        x.e   = b.e | (i == 162);
        x.src = (src == 1);
        xq.push_back(x);
      end
    end
  endtask

  task automatic drive_sources();
    in0_valid = (q0.size() > 0);
    in1_valid = (q1.size() > 0);
    if (in0_valid) begin
      in0_data = q0[0].d; in0_sop = q0[0].s; in0_eop = q0[0].e; in0_empty = q0[0].d[1:0];
    end else begin
      in0_data = '0; in0_sop = 1'b0; in0_eop = 1'b0; in0_empty = '0;
    end
    if (in1_valid) begin
      in1_data = q1[0].d; in1_sop = q1[0].s; in1_eop = q1[0].e; in1_empty = q1[0].d[1:0];
    end else begin
      in1_data = '0; in1_sop = 1'b0; in1_eop = 1'b0; in1_empty = '0;
    end
  endtask

  task automatic run(input int budget, input bit until_done);
    bit   a0, a1, oa;
    exp_t x;
    outbeats  = 0;
    dropped   = 0;
    first_acc = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      drive_sources();
      out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 2 == 0);
      #2;
      a0 = in0_valid & in0_ready;
      a1 = in1_valid & in1_ready;
      oa = out_valid & out_ready;
      if (out_valid)
        chk("ready_mirror", 64'(grant[1] ? in1_ready : in0_ready), 64'(out_ready));
      if (!src_enable[1])
        chk("disabled_in1_ready", 64'(in1_ready), 64'd0);
      if (oa) begin
        outbeats++;
        if (first_acc < 0) first_acc = cyc;
        if (xq.size() == 0) begin
          ncmp++;
          nerr++;
          $error("FAIL extra_beat: observed data %0h expected no beat", out_data);
        end else begin
          x = xq.pop_front();
          chk("out_data", 64'(out_data), 64'(x.d));
          chk("out_sop", 64'(out_sop), 64'(x.s));
          chk("out_eop", 64'(out_eop), 64'(x.e));
          chk("out_empty", 64'(out_empty), 64'(x.d[1:0]));
          chk("grant_beat", 64'(grant), x.src ? 64'd2 : 64'd1);
        end
      end
      if ((a0 | a1) && !out_valid) dropped++;
      @(posedge clk_clk);
      #1;
      if (a0) q0.delete(0);
      if (a1) q1.delete(0);
      if (stop_beats != 0 && outbeats == stop_beats) return;
      if (until_done && q0.size() == 0 && q1.size() == 0 && xq.size() == 0 && grant == 2'b00)
        return;
    end
    if (until_done || stop_beats != 0) begin
      ncmp++;
      nerr++;
      $error("FAIL run_budget: observed %0d cycles without completion expected completion", budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_sop"}, 64'(out_sop), 64'd0);
    chk({tag, "_out_eop"}, 64'(out_eop), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_empty"}, 64'(out_empty), 64'd0);
    chk({tag, "_in0_ready"}, 64'(in0_ready), 64'd0);
    chk({tag, "_in1_ready"}, 64'(in1_ready), 64'd0);
    chk({tag, "_grant"}, 64'(grant), 64'd0);
    chk({tag, "_pkt_cnt0"}, 64'(pkt_cnt0), 64'd0);
    chk({tag, "_pkt_cnt1"}, 64'(pkt_cnt1), 64'd0);
    chk({tag, "_trunc_cnt"}, 64'(trunc_cnt), 64'd0);
  endtask

  task automatic do_reset();
    int_rst = 1'b1;
    q0.delete();
    q1.delete();
    xq.delete();
    drive_sources();
    out_ready = 1'b1;
    @(posedge clk_clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk_clk);
    #1;
    int_rst = 1'b0;
  endtask

  initial begin
    src_enable = 2'b11;
    rdy_mode   = 0;
    do_reset();

    // Single 163-beat packet on input 0.
    add_pkt(0, 163, 162, 32'h1000_0000, 1);
    run(400, 1);
    chk("t1_latency", 64'(first_acc), 64'd1);
    chk("t1_beats", 64'(outbeats), 64'd163);
    chk("t1_pkt_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("t1_grant_idle", 64'(grant), 64'd0);

    // Both inputs contending: order 0,1,0,1 after reset.
    do_reset();
    add_pkt(0, 163, 162, 32'h2000_0000, 1);
    add_pkt(1, 163, 162, 32'h2100_0000, 1);
    add_pkt(0, 163, 162, 32'h2200_0000, 1);
    add_pkt(1, 163, 162, 32'h2300_0000, 1);
    run(1000, 1);
    chk("t2_beats_last_run", 64'(outbeats), 64'd652);
    chk("t2_pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    chk("t2_pkt_cnt1", 64'(pkt_cnt1), 64'd2);

    // Runaway 200-beat packet on input 1.
    add_pkt(1, 200, 199, 32'h3000_0000, 1);
    run(500, 1);
    chk("t3_beats", 64'(outbeats), 64'd163);
    chk("t3_dropped", 64'(dropped), 64'd37);
    chk("t3_trunc_cnt", 64'(trunc_cnt), 64'd1);
    chk("t3_pkt_cnt1", 64'(pkt_cnt1), 64'd2);

    // Backpressure toggling every cycle.
    rdy_mode = 1;
    add_pkt(0, 163, 162, 32'h4000_0000, 1);
    run(800, 1);
    chk("t4_beats", 64'(outbeats), 64'd163);
    chk("t4_pkt_cnt0", 64'(pkt_cnt0), 64'd3);
    rdy_mode = 0;

    // Input 1 masked while valid, then enabled.
    src_enable = 2'b01;
    add_pkt(0, 5, 4, 32'h5000_0000, 1);
    add_pkt(1, 4, 3, 32'h5100_0000, 1);
    run(20, 0);
    chk("t5_in1_waiting", 64'(q1.size()), 64'd4);
    chk("t5_exp_left", 64'(xq.size()), 64'd4);
    chk("t5_pkt_cnt0", 64'(pkt_cnt0), 64'd4);
    chk("t5_grant_idle", 64'(grant), 64'd0);
    src_enable = 2'b11;
    run(50, 1);
    chk("t5_latency_in1", 64'(first_acc), 64'd1);
    chk("t5_pkt_cnt1", 64'(pkt_cnt1), 64'd3);

    // Reset pulse in the middle of a packet.
    add_pkt(0, 163, 162, 32'h6000_0000, 1);
    stop_beats = 50;
    run(400, 0);
    stop_beats = 0;
    drive_sources();
    #1;
    chk("t6_mid_valid", 64'(out_valid), 64'd1);
    chk("t6_mid_data", 64'(out_data), 64'h6000_0032);
    int_rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk_clk);
    q0.delete();
    q1.delete();
    xq.delete();
    drive_sources();
    @(posedge clk_clk);
    #1;
    int_rst = 1'b0;
    add_pkt(1, 3, 2, 32'h7000_0000, 1);
    run(50, 1);
    chk("t6_latency", 64'(first_acc), 64'd1);
    chk("t6_beats", 64'(outbeats), 64'd3);
    chk("t6_pkt_cnt1", 64'(pkt_cnt1), 64'd1);
    chk("t6_pkt_cnt0", 64'(pkt_cnt0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
